// File: rtl/ext_mem_bridge.sv
// External-memory endpoint for ElectronNest: boot streamer, latency-configurable load port, store port.
// Optional ADDR_INDEX_EN: carry the accepted load address on O_Ld_FTk.i.
package ext_mem_bridge_pkg;
  localparam int unsigned WIDTH_DATA   = 32;
  localparam int unsigned WIDTH_EXADDR = 32;
  localparam int unsigned WIDTH_INDEX  = 8;

  typedef struct packed {
    logic                   v;
    logic                   a;
    logic                   r;
    logic                   c;
    logic [WIDTH_INDEX-1:0] i;
    logic [WIDTH_DATA-1:0]  d;
  } FTk_t;

  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } BTk_t;
endpackage

module ext_mem_bridge
  import ext_mem_bridge_pkg::*;
#(
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned NUM_BOOT_PRE   = 3,
  parameter int unsigned NUM_BOOT_WORDS = 5,
  parameter int unsigned BOOT_BASE      = 0,
  parameter int unsigned LD_LATENCY     = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          I_Boot,
  output logic                          O_Boot_Busy,
  input  logic                          I_Pre_We,
  input  logic [$clog2(DEPTH)-1:0]      I_Pre_Addr,
  input  logic [WIDTH_DATA-1:0]         I_Pre_Data,
  input  logic                          I_Ld_Req,
  input  logic [WIDTH_EXADDR-1:0]       I_Ld_Addr,
  output logic                          O_Ld_Rdy,
  output FTk_t                          O_Ld_FTk,
  input  BTk_t                          I_Ld_BTk,
  input  logic                          I_St_Req,
  input  logic [WIDTH_EXADDR-1:0]       I_St_Addr,
  input  FTk_t                          I_St_FTk,
  output BTk_t                          O_St_BTk,
  output logic                          O_St_Err
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = 16;
  localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(NUM_BOOT_PRE - 1);
  localparam logic [CNT_W-1:0] WORDS_LAST = CNT_W'(NUM_BOOT_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_BOOT, S_RUN} state_t;

  localparam state_t BOOT_ENTRY = (NUM_BOOT_PRE != 0)   ? S_PRE  :
                                  (NUM_BOOT_WORDS != 0) ? S_BOOT : S_RUN;
  localparam state_t PRE_EXIT   = (NUM_BOOT_WORDS != 0) ? S_BOOT : S_RUN;

  logic [WIDTH_DATA-1:0] r_mem [DEPTH];
  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  r_busy;
  logic                  r_st_n;
  logic                  r_err;
  FTk_t                  r_stage [LD_LATENCY];
  FTk_t                  w_boot_tk;
  FTk_t                  w_acc_tk;
  logic                  w_boot_emit;
  logic                  w_stall;
  logic                  w_ld_acc;
  logic                  w_ld_inr;
  logic                  w_st_inr;
  logic                  w_st_go;
  logic                  w_st_we;
  logic                  w_st_oor;
  logic [ADDR_W-1:0]     w_boot_addr;
  logic                  w_unused_c;

  assign w_stall     = I_Ld_BTk.n;
  assign w_boot_addr = ADDR_W'(BOOT_BASE) + ADDR_W'(r_cnt);
  assign w_ld_inr    = (I_Ld_Addr < WIDTH_EXADDR'(DEPTH));
  assign w_st_inr    = (I_St_Addr < WIDTH_EXADDR'(DEPTH));
  assign w_st_go     = I_St_Req & I_St_FTk.v & ~r_st_n;
  assign w_st_we     = w_st_go & w_st_inr;
  assign w_st_oor    = w_st_go & ~w_st_inr;
  assign w_ld_acc    = I_Ld_Req & O_Ld_Rdy;
  assign w_unused_c  = ^{I_Ld_BTk.t, I_Ld_BTk.v, I_Ld_BTk.c,
                         I_St_FTk.a, I_St_FTk.r, I_St_FTk.c, I_St_FTk.i};

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; boot progress freezes while the fabric nacks
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (I_Boot) w_state_nxt = BOOT_ENTRY;
      S_PRE:   if (!w_stall && r_cnt == PRE_LAST) w_state_nxt = PRE_EXIT;
      S_BOOT:  if (!w_stall && r_cnt == WORDS_LAST) w_state_nxt = S_RUN;
      default: w_state_nxt = r_state;
    endcase
  end

  // Output logic: boot word under construction and counter update
  always_comb begin
    w_boot_emit = 1'b0;
    w_boot_tk   = '0;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_PRE: begin
        w_boot_emit = 1'b1;
        w_boot_tk.v = 1'b1;
        w_boot_tk.a = (r_cnt == '0);
      end
      S_BOOT: begin
        w_boot_emit = 1'b1;
        w_boot_tk.v = 1'b1;
        w_boot_tk.a = (NUM_BOOT_PRE == 0) && (r_cnt == '0);
        w_boot_tk.d = r_mem[w_boot_addr];
      end
      default: w_boot_emit = 1'b0;
    endcase
    if (w_boot_emit && !w_stall)
      w_cnt_nxt = (w_state_nxt != r_state) ? '0 : r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_st_n <= 1'b1;
      r_err  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_busy <= (w_state_nxt == S_PRE) || (w_state_nxt == S_BOOT);
      r_st_n <= (w_state_nxt != S_RUN);
      if (w_st_oor) r_err <= 1'b1;
    end
  end

  // Stage-1 token for an accepted load, with write-first bypass from a same-cycle store
  always_comb begin
    w_acc_tk = '0;
    if (w_ld_acc) begin
      w_acc_tk.v = 1'b1;
      if (w_ld_inr)
        w_acc_tk.d = (w_st_we && I_St_Addr == I_Ld_Addr) ? I_St_FTk.d
                                                         : r_mem[ADDR_W'(I_Ld_Addr)];
`ifdef ADDR_INDEX_EN
      w_acc_tk.i = WIDTH_INDEX'(I_Ld_Addr);
`else
      w_acc_tk.i = '0;
`endif
    end
  end

  // Load pipeline; the last stage is the output token and also carries boot words
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < LD_LATENCY; k++) r_stage[k] <= '0;
    end else if (!w_stall) begin
      r_stage[0] <= w_acc_tk;
      for (int k = 1; k < LD_LATENCY; k++) r_stage[k] <= r_stage[k-1];
      if (w_boot_emit) r_stage[LD_LATENCY-1] <= w_boot_tk;
    end
  end

  // Memory array is intentionally not reset
  always_ff @(posedge clock) begin
    if (r_state == S_IDLE && I_Pre_We) r_mem[I_Pre_Addr] <= I_Pre_Data;
    else if (w_st_we)                  r_mem[ADDR_W'(I_St_Addr)] <= I_St_FTk.d;
  end

  always_comb begin
    O_St_BTk   = '0;
    O_St_BTk.n = r_st_n;
  end

  assign O_Ld_FTk    = r_stage[LD_LATENCY-1];
  assign O_Ld_Rdy    = (r_state == S_RUN) & ~w_stall;
  assign O_Boot_Busy = r_busy;
  assign O_St_Err    = r_err;

endmodule
